mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl_pkg.sv | 27 ++
 rtl/mdu_div_iter.sv | 59 +++++
 rtl/mdu_ctrl.sv | 154 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: op codes, divider states
// and a two's-complement magnitude helper.
package mdu_ctrl_pkg;

    localparam int unsigned MDOP_W = 4;

    typedef enum logic [MDOP_W-1:0] {
        MDOP_NOP   = 4'd0,
        MDOP_MULT  = 4'd1,
        MDOP_MULTU = 4'd2,
        MDOP_DIV   = 4'd3,
        MDOP_DIVU  = 4'd4,
        MDOP_MTHI  = 4'd5,
        MDOP_MTLO  = 4'd6
    } mdop_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIX
    } div_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Iterative unsigned restoring divider core: one quotient bit per cycle.
// done_o flags the cycle whose closing edge performs the final step.
module mdu_div_iter
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    localparam int unsigned CNT_W = $clog2(DIV_ITERS + 1);

    logic [31:0]      rem_q, quot_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [32:0]      shifted, diff;

    // A zero divisor never borrows, so the quotient fills with ones and the
    // remainder ends up holding the dividend without any special casing.
    assign shifted = {rem_q, quot_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quot_q <= dividend_i;
            dvs_q  <= divisor_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= diff[32] ? shifted[31:0] : diff[31:0];
            quot_q <= {quot_q[30:0], ~diff[32]};
            cnt_q  <= cnt_q + 1'b1;
            if (done_o) busy_q <= 1'b0;
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_W'(DIV_ITERS - 1));
    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide controller: HI/LO ownership, 2-stage multiply pipe
// (also carrying MTHI/MTLO for ordering) and a sign-fixing wrapper around the divider.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic [MDOP_W-1:0] mdu_op_i,
    input  logic [31:0]       opr1_i,
    input  logic [31:0]       opr2_i,
    output logic              mdu_is_active_o,
    output logic              mdu_div_active_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o
);

    mdop_e       op;
    logic        issue_ok, iss_mul, iss_div;

    logic        s1_vld_q, s2_vld_q;
    mdop_e       s1_op_q, s2_op_q;
    logic [31:0] s1_a_q, s1_b_q;
    logic [63:0] s2_res_q, s2_res_d;

    div_state_e  st_q, st_d;
    logic        sgn_a_q, sgn_b_q, signed_q;
    logic        iter_done;
    logic [31:0] quot, rem, q_fix, r_fix;
    logic        div_wr;

    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    assign op       = mdop_e'(mdu_op_i);
    assign issue_ok = ~stall_i & ~flush_i;
    assign iss_mul  = issue_ok & ~mdu_div_active_o &
                      (op inside {MDOP_MULT, MDOP_MULTU, MDOP_MTHI, MDOP_MTLO});
    assign iss_div  = issue_ok & ~mdu_is_active_o & (op inside {MDOP_DIV, MDOP_DIVU});

    always_comb begin
        s2_res_d = {32'd0, s1_a_q};
        unique case (s1_op_q)
            MDOP_MULT:  s2_res_d = {{32{s1_a_q[31]}}, s1_a_q} * {{32{s1_b_q[31]}}, s1_b_q};
            MDOP_MULTU: s2_res_d = {32'd0, s1_a_q} * {32'd0, s1_b_q};
            default:    s2_res_d = {32'd0, s1_a_q};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_op_q  <= MDOP_NOP;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_op_q  <= MDOP_NOP;
            s2_res_q <= '0;
        end else begin
            s1_vld_q <= iss_mul;
            if (iss_mul) begin
                s1_op_q <= op;
                s1_a_q  <= opr1_i;
                s1_b_q  <= opr2_i;
            end
            s2_vld_q <= s1_vld_q & ~flush_i;
            s2_op_q  <= s1_op_q;
            s2_res_q <= s2_res_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            DIV_IDLE: if (iss_div) st_d = DIV_RUN;
            DIV_RUN:  if (iter_done) st_d = DIV_FIX;
            DIV_FIX:  st_d = DIV_IDLE;
            default:  st_d = DIV_IDLE;
        endcase
        if (flush_i) st_d = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= DIV_IDLE;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            st_q <= st_d;
            if (iss_div) begin
                sgn_a_q  <= opr1_i[31];
                sgn_b_q  <= opr2_i[31];
                signed_q <= (op == MDOP_DIV);
            end
        end
    end

    mdu_div_iter #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (iss_div),
        .abort_i    (flush_i),
        .dividend_i ((op == MDOP_DIV) ? abs32(opr1_i) : opr1_i),
        .divisor_i  ((op == MDOP_DIV) ? abs32(opr2_i) : opr2_i),
        .done_o     (iter_done),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    assign q_fix  = (signed_q & (sgn_a_q ^ sgn_b_q)) ? (~quot + 32'd1) : quot;
    assign r_fix  = (signed_q & sgn_a_q) ? (~rem + 32'd1) : rem;
    assign div_wr = (st_q == DIV_FIX) & ~flush_i;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (s2_vld_q && !flush_i) begin
            unique case (s2_op_q)
                MDOP_MULT, MDOP_MULTU: begin
                    hi_d = s2_res_q[63:32];
                    lo_d = s2_res_q[31:0];
                end
                MDOP_MTHI: hi_d = s2_res_q[31:0];
                MDOP_MTLO: lo_d = s2_res_q[31:0];
                default: ;
            endcase
        end
        if (div_wr) begin
            hi_d = r_fix;
            lo_d = q_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign mdu_div_active_o = (st_q != DIV_IDLE);
    assign mdu_is_active_o  = s1_vld_q | s2_vld_q | mdu_div_active_o;
    assign hi_o             = hi_q;
    assign lo_o             = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: multiply pipe, divider timing and
// corner cases, flush, stall and asynchronous reset mid-divide.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush_i = 1'b0;
    logic              stall_i = 1'b0;
    logic [MDOP_W-1:0] mdu_op_i = MDOP_NOP;
    logic [31:0]       opr1_i = '0;
    logic [31:0]       opr2_i = '0;
    logic              mdu_is_active_o, mdu_div_active_o;
    logic [31:0]       hi_o, lo_o;

    int n_chk = 0;
    int n_err = 0;

    mdu_ctrl #(
        .DIV_ITERS (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .stall_i          (stall_i),
        .mdu_op_i         (mdu_op_i),
        .opr1_i           (opr1_i),
        .opr2_i           (opr2_i),
        .mdu_is_active_o  (mdu_is_active_o),
        .mdu_div_active_o (mdu_div_active_o),
        .hi_o             (hi_o),
        .lo_o             (lo_o)
    );

    always #5 clk = ~clk;

    // Guard against the bench itself issuing an op the controller would drop.
    always @(posedge clk) begin
        if (rst_n && !stall_i && !flush_i) begin
            if (mdu_op_i == MDOP_DIV || mdu_op_i == MDOP_DIVU)
                assert (!mdu_is_active_o) else $error("illegal divide issue");
            if (mdu_op_i inside {MDOP_MULT, MDOP_MULTU, MDOP_MTHI, MDOP_MTLO})
                assert (!mdu_div_active_o) else $error("illegal multiply issue");
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [MDOP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu_op_i = op;
        opr1_i   = a;
        opr2_i   = b;
        tick();
        mdu_op_i = MDOP_NOP;
    endtask

    task automatic run_mul(input string tag, input logic [MDOP_W-1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b);
        check({tag, ".active_e0"}, mdu_is_active_o, 1'b1);
        tick();
        tick();
        check({tag, ".hi"}, hi_o, exp_hi);
        check({tag, ".lo"}, lo_o, exp_lo);
        check({tag, ".idle_e2"}, mdu_is_active_o, 1'b0);
    endtask

    task automatic run_div(input string tag, input logic [MDOP_W-1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        issue(op, a, b);
        cyc = 0;
        while (mdu_div_active_o && cyc < 100) begin
            cyc++;
            tick();
        end
        check({tag, ".cycles"}, 64'(cyc), 64'd33);
        check({tag, ".hi"}, hi_o, exp_hi);
        check({tag, ".lo"}, lo_o, exp_lo);
    endtask

    initial begin
        #2;
        check("rst.hi", hi_o, 32'd0);
        check("rst.lo", lo_o, 32'd0);
        check("rst.active", mdu_is_active_o, 1'b0);
        check("rst.div_active", mdu_div_active_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_mul("mult",  MDOP_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mul("multu", MDOP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);

        run_div("div_m7_2",   MDOP_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu_7_0",   MDOP_DIVU, 32'd7,         32'd0,          32'd7,         32'hFFFF_FFFF);
        run_div("div_min_m1", MDOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        run_div("divu_100_7", MDOP_DIVU, 32'd100,       32'd7,          32'd2,         32'd14);
        run_div("div_7_m2",   MDOP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);

        // Back-to-back MULT, MTLO, MTHI retire in issue order.
        mdu_op_i = MDOP_MULT; opr1_i = 32'd3;      opr2_i = 32'd5; tick();
        mdu_op_i = MDOP_MTLO; opr1_i = 32'h1234;   opr2_i = 32'd0; tick();
        mdu_op_i = MDOP_MTHI; opr1_i = 32'hABCD;                   tick();
        mdu_op_i = MDOP_NOP;
        check("b2b.hi_1", hi_o, 32'd0);
        check("b2b.lo_1", lo_o, 32'd15);
        tick();
        check("b2b.hi_2", hi_o, 32'd0);
        check("b2b.lo_2", lo_o, 32'h1234);
        tick();
        check("b2b.hi_3", hi_o, 32'hABCD);
        check("b2b.lo_3", lo_o, 32'h1234);
        check("b2b.idle", mdu_is_active_o, 1'b0);

        // Flush aborts a running divide without touching HI/LO.
        issue(MDOP_DIVU, 32'd100, 32'd7);
        repeat (9) tick();
        check("flush_div.pre", mdu_div_active_o, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_div.div_active", mdu_div_active_o, 1'b0);
        check("flush_div.active", mdu_is_active_o, 1'b0);
        repeat (40) tick();
        check("flush_div.hi", hi_o, 32'hABCD);
        check("flush_div.lo", lo_o, 32'h1234);

        // Flush on the edge where s2 would write suppresses that write.
        issue(MDOP_MULT, 32'd3, 32'd5);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_s2.hi", hi_o, 32'hABCD);
        check("flush_s2.lo", lo_o, 32'h1234);
        check("flush_s2.active", mdu_is_active_o, 1'b0);
        tick();
        check("flush_s2.lo_late", lo_o, 32'h1234);

        // Stall blocks issue.
        stall_i = 1'b1;
        issue(MDOP_MULT, 32'd3, 32'd5);
        check("stall.active", mdu_is_active_o, 1'b0);
        stall_i = 1'b0;
        tick();
        tick();
        check("stall.lo", lo_o, 32'h1234);

        // Asynchronous reset in the middle of a divide.
        mdu_op_i = MDOP_MTHI; opr1_i = 32'd5; tick();
        mdu_op_i = MDOP_MTLO; opr1_i = 32'd5; tick();
        mdu_op_i = MDOP_NOP;
        tick();
        tick();
        check("pre_rst.hi", hi_o, 32'd5);
        check("pre_rst.lo", lo_o, 32'd5);
        issue(MDOP_DIVU, 32'd100, 32'd7);
        repeat (19) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst.hi", hi_o, 32'd0);
        check("mid_rst.lo", lo_o, 32'd0);
        check("mid_rst.active", mdu_is_active_o, 1'b0);
        check("mid_rst.div_active", mdu_div_active_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) tick();
        check("post_rst.hi", hi_o, 32'd0);
        check("post_rst.lo", lo_o, 32'd0);
        check("post_rst.div_active", mdu_div_active_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
